vga_timing_gen: RTL and testbench

VGA 640x480@60 Hz timing generator and pixel output stage for the Nexys4 Bomberman top level. It divides the 100 MHz system clock down to a 25 MHz pixel strobe and runs the horizontal and vertical counters. Each pixel period it hands the current pixel coordinate to the renderer and registers the renderer's 12-bit colour onto the board's hSync/vSync/vgaR/vgaG/vgaB pins. It also issues a once-per-frame tick that game logic uses to update state during vertical blanking.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides CLK to a pixel strobe, runs the raster counters,
// and registers sync plus blanked colour one pixel period behind the counters.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        game_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       V_TICK   = 10'(V_ACTIVE - 1);

  // Sync window bounds compared at 11 bits so a window ending at 1024 still works
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);

  logic [DIV_W-1:0] div_cnt;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;
  logic             in_hsync;
  logic             in_vsync;

  always_comb begin
    h_ext     = {1'b0, hCount};
    v_ext     = {1'b0, vCount};
    pix_en    = (div_cnt == DIV_LAST);
    bright    = (h_ext < H_VIS) && (v_ext < V_VIS);
    in_hsync  = (h_ext >= HS_START) && (h_ext < HS_END);
    in_vsync  = (v_ext >= VS_START) && (v_ext < VS_END);
    game_tick = pix_en && (hCount == H_LAST) && (vCount == V_TICK);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  // Captures the pixel being left, so sync and colour share one pixel of lag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      vgaR  <= '0;
      vgaG  <= '0;
      vgaB  <= '0;
    end else if (pix_en) begin
      hSync <= ~in_hsync;
      vSync <= ~in_vsync;
      {vgaR, vgaG, vgaB} <= bright ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk raster with random/coordinate/constant colour,
// plus a default-size instance checked for line timing, against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int unsigned SD  = 3;
  localparam int unsigned SHA = 20, SHF = 3, SHS = 5, SHB = 4;
  localparam int unsigned SVA = 12, SVF = 2, SVS = 2, SVB = 3;

  typedef struct packed {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        bright;
    logic        pe;
    logic        gt;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [11:0] s_rgb = 12'hFFF;

  logic [9:0]  s_hc, s_vc, d_hc, d_vc;
  logic        s_br, s_pe, s_gt, s_hs, s_vs;
  logic        d_br, d_pe, d_gt, d_hs, d_vs;
  logic [3:0]  s_r, s_g, s_b, d_r, d_g, d_b;

  int unsigned n = 0;
  int          vectors = 0;
  int          errors = 0;
  int          mode = 0;
  logic [11:0] cap_s = '0;

  always #5 CLK = ~CLK;

  vga_timing_gen #(
    .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .CLK(CLK), .RESET_N(RESET_N), .rgb_in(s_rgb),
    .hCount(s_hc), .vCount(s_vc), .bright(s_br), .pix_en(s_pe), .game_tick(s_gt),
    .hSync(s_hs), .vSync(s_vs), .vgaR(s_r), .vgaG(s_g), .vgaB(s_b)
  );

  vga_timing_gen u_def (
    .CLK(CLK), .RESET_N(RESET_N), .rgb_in(12'hA5C),
    .hCount(d_hc), .vCount(d_vc), .bright(d_br), .pix_en(d_pe), .game_tick(d_gt),
    .hSync(d_hs), .vSync(d_vs), .vgaR(d_r), .vgaG(d_g), .vgaB(d_b)
  );

  // Raster state after t CLK edges since reset release; cap is the colour presented
  // at the last pixel strobe.
  function automatic exp_t model(int unsigned t, int unsigned d,
                                 int unsigned ha, int unsigned hf, int unsigned hs, int unsigned hb,
                                 int unsigned va, int unsigned vf, int unsigned vs, int unsigned vb,
                                 logic [11:0] cap);
    int unsigned ht, vt, p, x, y, cx, cy;
    exp_t e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = t / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    e.hc     = 10'(x);
    e.vc     = 10'(y);
    e.bright = (x < ha) && (y < va);
    e.pe     = (t % d) == d - 1;
    e.gt     = e.pe && (x == ht - 1) && (y == va - 1);
    if (p == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = '0;
    end else begin
      cx = (p - 1) % ht;
      cy = ((p - 1) / ht) % vt;
      e.hs  = !(cx >= ha + hf && cx < ha + hf + hs);
      e.vs  = !(cy >= va + vf && cy < va + vf + vs);
      e.rgb = (cx < ha && cy < va) ? cap : 12'h000;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic check_all();
    exp_t es, ed;
    es = model(n, SD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, cap_s);
    ed = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 12'hA5C);
    chk("s_hCount", 32'(s_hc), 32'(es.hc));
    chk("s_vCount", 32'(s_vc), 32'(es.vc));
    chk("s_bright", 32'(s_br), 32'(es.bright));
    chk("s_pix_en", 32'(s_pe), 32'(es.pe));
    chk("s_game_tick", 32'(s_gt), 32'(es.gt));
    chk("s_hSync", 32'(s_hs), 32'(es.hs));
    chk("s_vSync", 32'(s_vs), 32'(es.vs));
    chk("s_rgb", 32'({s_r, s_g, s_b}), 32'(es.rgb));
    chk("d_hCount", 32'(d_hc), 32'(ed.hc));
    chk("d_pix_en", 32'(d_pe), 32'(ed.pe));
    chk("d_game_tick", 32'(d_gt), 32'(ed.gt));
    chk("d_hSync", 32'(d_hs), 32'(ed.hs));
    chk("d_vSync", 32'(d_vs), 32'(ed.vs));
    chk("d_rgb", 32'({d_r, d_g, d_b}), 32'(ed.rgb));
  endtask

  // Choose the next renderer colour; remember what the coming strobe will capture
  task automatic drive();
    exp_t es;
    es = model(n, SD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, cap_s);
    case (mode)
      0:       s_rgb = 12'($urandom);
      1:       s_rgb = {2'b00, s_hc};
      default: s_rgb = 12'hA5C;
    endcase
    if (es.pe) cap_s = (mode == 1) ? {2'b00, es.hc} : s_rgb;
  endtask

  task automatic step();
    @(posedge CLK);
    n++;
    #1;
    check_all();
    drive();
  endtask

  initial begin
    exp_t es;
    bit found;

    // Reset held with white on the renderer input
    #22;
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;
    n = 0;
    drive();

    mode = 0;
    for (int i = 0; i < 2000; i++) step();
    mode = 1;
    for (int i = 0; i < 2000; i++) step();
    mode = 2;
    for (int i = 0; i < 3200; i++) step();

    // Mid-frame reset while the small raster is inside its hSync pulse
    mode = 0;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      es = model(n, SD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, cap_s);
      if (!es.hs && es.vc == 10'd6) found = 1'b1;
    end
    chk("reset_search", 32'(found), 32'd1);
    chk("hs_low_before_reset", 32'(s_hs), 32'd0);
    #2;
    RESET_N = 1'b0;
    n = 0;
    #1;
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;
    drive();
    for (int i = 0; i < 4000; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
